sd_adc_array: RTL and testbench



---
 rtl/sd_adc_pkg.sv | 11 +
 rtl/sd_cic_channel.sv | 45 ++++
 rtl/sd_adc_array.sv | 101 ++++++++++
 tb/tb_sd_adc_array.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sd_adc_pkg.sv
// sd_adc_pkg: shared constants, stream FSM states and sizing/clamp helpers for sd_adc_array
package sd_adc_pkg;
  localparam int OSR_MIN = 4;
  typedef enum logic {IDLE, DRAIN} state_t;
  function automatic int cic_w(input int order, input int osr_max);
    return order * $clog2(osr_max) + 1;
  endfunction
  function automatic int clamp_osr(input int v, input int osr_max);
    return v < OSR_MIN ? OSR_MIN : (v > osr_max ? osr_max : v);
  endfunction
endpackage

// File: rtl/sd_cic_channel.sv
// sd_cic_channel: one sigma-delta channel (clk, rst, tick, boundary, stg comb enables, comp in, dac out, scaled data out)
module sd_cic_channel
  import sd_adc_pkg::*;
#(
  parameter int CIC_ORDER = 3,
  parameter int OSR_MAX   = 256,
  parameter int OUT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 boundary,
  input  logic [CIC_ORDER-1:0] stg,
  input  logic                 comp,
  output logic                 dac,
  output logic [OUT_W-1:0]     data
);
  localparam int CIC_W = cic_w(CIC_ORDER, OSR_MAX);
  localparam int SH    = CIC_W > OUT_W ? CIC_W - OUT_W : 0;
  logic [CIC_W-1:0] integ [CIC_ORDER];
  logic [CIC_W-1:0] c     [CIC_ORDER+1];
  logic [CIC_W-1:0] d     [CIC_ORDER];
  always_ff @(posedge clk)
    if (rst) begin
      dac <= 1'b0;
      for (int k = 0; k < CIC_ORDER; k++) begin
        integ[k] <= '0;
        d[k]     <= '0;
      end
      for (int k = 0; k <= CIC_ORDER; k++) c[k] <= '0;
    end else begin
      if (tick) begin
        dac      <= comp;
        integ[0] <= integ[0] + CIC_W'(dac);
        for (int k = 1; k < CIC_ORDER; k++) integ[k] <= integ[k] + integ[k-1];
      end
      if (boundary) c[0] <= integ[CIC_ORDER-1];
      for (int k = 0; k < CIC_ORDER; k++)
        if (stg[k]) begin
          c[k+1] <= c[k] - d[k];
          d[k]   <= c[k];
        end
    end
  assign data = OUT_W'(c[CIC_ORDER] >> SH);
endmodule

// File: rtl/sd_adc_array.sv
// sd_adc_array: N_CH sigma-delta ADC front end (clk, rst, enable, osr_cfg, comp_in/dac_out, m_* sample stream, frame/overrun counters)
module sd_adc_array
  import sd_adc_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int TICK_DIV  = 50,
  parameter int OSR_MAX   = 256,
  parameter int CIC_ORDER = 3,
  parameter int OUT_W     = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  logic [$clog2(OSR_MAX+1)-1:0]        osr_cfg,
  input  logic [N_CH-1:0]                     comp_in,
  output logic [N_CH-1:0]                     dac_out,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [OUT_W-1:0]                    m_data,
  output logic [(N_CH>1?$clog2(N_CH):1)-1:0]  m_chan,
  output logic                                m_last,
  output logic                                m_unsettled,
  output logic [15:0]                         frame_cnt,
  output logic                                overrun,
  output logic [7:0]                          overrun_cnt,
  input  logic                                clr_overrun
);
  localparam int OSR_W = $clog2(OSR_MAX+1);
  localparam int CH_W  = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int DIV_W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int UW    = $clog2(CIC_ORDER+1);
  state_t               state, nxt;
  logic [DIV_W-1:0]     div;
  logic [OSR_W-1:0]     dec, osr_active, osr_new;
  logic [UW-1:0]        uns_cnt;
  logic [CIC_ORDER:0]   pipe;
  logic [CH_W-1:0]      rd_ptr;
  logic [OUT_W-1:0]     frame   [N_CH];
  logic [OUT_W-1:0]     ch_data [N_CH];
  logic                 tick, boundary, commit, xfer, last_xfer, load, drop;
  assign tick      = enable && div == DIV_W'(TICK_DIV-1);
  assign boundary  = tick && dec == osr_active - 1'b1;
  assign osr_new   = OSR_W'(clamp_osr(int'(osr_cfg), OSR_MAX));
  assign commit    = pipe[CIC_ORDER];
  assign xfer      = m_valid && m_ready;
  assign last_xfer = xfer && rd_ptr == CH_W'(N_CH-1);
  assign load      = commit && (state == IDLE || last_xfer);
  assign drop      = commit && !load;
  assign m_valid   = state == DRAIN;
  assign m_data    = frame[rd_ptr];
  assign m_chan    = rd_ptr;
  assign m_last    = m_valid && rd_ptr == CH_W'(N_CH-1);
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb nxt = load ? DRAIN : last_xfer ? IDLE : state;
  always_ff @(posedge clk)
    if (rst) begin
      div         <= '0;
      dec         <= '0;
      osr_active  <= OSR_W'(OSR_MAX);
      uns_cnt     <= UW'(CIC_ORDER);
      pipe        <= '0;
      rd_ptr      <= '0;
      frame_cnt   <= '0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
      m_unsettled <= 1'b0;
      for (int i = 0; i < N_CH; i++) frame[i] <= '0;
    end else begin
      if (enable) div <= tick ? '0 : div + 1'b1;
      if (tick) dec <= boundary ? '0 : dec + 1'b1;
      pipe <= {pipe[CIC_ORDER-1:0], boundary};
      if (boundary) osr_active <= osr_new;
      if (boundary && osr_new != osr_active) uns_cnt <= UW'(CIC_ORDER);
      else if (commit && uns_cnt != '0) uns_cnt <= uns_cnt - 1'b1;
      if (load) begin
        for (int i = 0; i < N_CH; i++) frame[i] <= ch_data[i];
        m_unsettled <= uns_cnt != '0;
        frame_cnt   <= frame_cnt + 1'b1;
      end
      rd_ptr <= load ? '0 : xfer ? rd_ptr + 1'b1 : rd_ptr;
      if (drop) begin
        overrun     <= 1'b1;
        overrun_cnt <= clr_overrun ? 8'd1 : overrun_cnt + 8'(overrun_cnt != 8'hFF);
      end else if (clr_overrun) begin
        overrun     <= 1'b0;
        overrun_cnt <= '0;
      end
    end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sd_cic_channel #(.CIC_ORDER(CIC_ORDER), .OSR_MAX(OSR_MAX), .OUT_W(OUT_W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .boundary (boundary),
      .stg      (pipe[CIC_ORDER-1:0]),
      .comp     (comp_in[i]),
      .dac      (dac_out[i]),
      .data     (ch_data[i])
    );
  end
endmodule

// File: tb/tb_sd_adc_array.sv
// tb_sd_adc_array: scoreboard bench for sd_adc_array with directed frame vectors
`timescale 1ns/1ps
module tb_sd_adc_array;
  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, m_ready = 1'b0, clr_overrun = 1'b0;
  logic [8:0]  osr_cfg = 9'd256;
  logic [3:0]  comp_in = 4'h0;
  logic [3:0]  dac_out;
  logic        m_valid, m_last, m_unsettled, overrun;
  logic [15:0] m_data, frame_cnt;
  logic [1:0]  m_chan;
  logic [7:0]  overrun_cnt;
  typedef struct packed {logic dc; logic [15:0] data; logic [1:0] chan; logic last; logic uns;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, cyc = 0;
  sd_adc_array #(.N_CH(4), .TICK_DIV(5), .OSR_MAX(256), .CIC_ORDER(3), .OUT_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .osr_cfg(osr_cfg), .comp_in(comp_in), .dac_out(dac_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_chan(m_chan), .m_last(m_last),
    .m_unsettled(m_unsettled), .frame_cnt(frame_cnt), .overrun(overrun), .overrun_cnt(overrun_cnt),
    .clr_overrun(clr_overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic push_frame(input logic dc, input logic [15:0] d, input logic u);
    for (int c = 0; c < 4; c++) q.push_back('{dc, d, 2'(c), c == 3, u});
  endtask
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset(input logic [3:0] comp, input logic rdy);
    rst = 1'b1; comp_in = comp; m_ready = rdy; osr_cfg = 9'd256; clr_overrun = 1'b0; enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_dac_out", dac_out, 0);
    chk("rst_overrun", {overrun, overrun_cnt}, 0);
    chk("rst_m_data", m_data, 0);
    q.delete();
    rst = 1'b0;
  endtask
  always @(negedge clk)
    if (!rst && m_valid && m_ready) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_sample: got chan %0d data %h, expected no sample (cyc %0d)", m_chan, m_data, cyc);
      end else begin
        e = q.pop_front();
        if (m_chan !== e.chan || m_last !== e.last || m_unsettled !== e.uns || (!e.dc && m_data !== e.data)) begin
          failures++;
          $display("FAIL sample: got chan %0d last %b uns %b data %h, expected chan %0d last %b uns %b data %h%s (cyc %0d)",
                   m_chan, m_last, m_unsettled, m_data, e.chan, e.last, e.uns, e.data, e.dc ? " (any)" : "", cyc);
        end
      end
    end
  initial begin
    do_reset(4'hF, 1'b1);
    for (int f = 1; f <= 3; f++) push_frame(1'b1, 16'h0, 1'b1);
    push_frame(1'b0, 16'h8000, 1'b0);
    push_frame(1'b0, 16'h8000, 1'b0);
    push_frame(1'b0, 16'h8000, 1'b0);
    wait_cyc(6407);
    m_ready = 1'b0;
    wait_cyc(7683);
    chk("wrap_held_valid", m_valid, 1);
    chk("wrap_held_chan", m_chan, 3);
    m_ready = 1'b1;
    wait_cyc(7684);
    chk("wrap_valid_no_gap", m_valid, 1);
    chk("wrap_chan0", m_chan, 0);
    chk("wrap_frame_cnt", frame_cnt, 6);
    chk("wrap_no_overrun", overrun, 0);
    wait_cyc(7700);
    chk("seg1_queue_empty", q.size(), 0);
    do_reset(4'h0, 1'b1);
    for (int f = 1; f <= 3; f++) push_frame(1'b0, 16'h0, 1'b1);
    push_frame(1'b0, 16'h0, 1'b0);
    wait_cyc(1283);
    chk("zero_frame_cnt_before", frame_cnt, 0);
    wait_cyc(1284);
    chk("zero_frame_cnt_1", frame_cnt, 1);
    wait_cyc(2564);
    chk("zero_frame_cnt_2", frame_cnt, 2);
    wait_cyc(5130);
    chk("zero_frame_cnt_4", frame_cnt, 4);
    chk("zero_dac_out", dac_out, 0);
    chk("zero_queue_empty", q.size(), 0);
    do_reset(4'hF, 1'b1);
    for (int f = 1; f <= 3; f++) push_frame(1'b1, 16'h0, 1'b1);
    push_frame(1'b0, 16'h8000, 1'b0);
    wait_cyc(6000);
    osr_cfg = 9'd128;
    push_frame(1'b0, 16'h8000, 1'b1);
    push_frame(1'b1, 16'h0, 1'b1);
    push_frame(1'b1, 16'h0, 1'b1);
    push_frame(1'b0, 16'h1000, 1'b0);
    wait_cyc(8700);
    osr_cfg = 9'd2;
    push_frame(1'b0, 16'h1000, 1'b1);
    push_frame(1'b1, 16'h0, 1'b1);
    push_frame(1'b1, 16'h0, 1'b1);
    push_frame(1'b0, 16'h0, 1'b0);
    push_frame(1'b0, 16'h0, 1'b0);
    wait_cyc(9050);
    chk("osr_frame_cnt", frame_cnt, 13);
    chk("osr_queue_empty", q.size(), 0);
    do_reset(4'hF, 1'b1);
    for (int f = 1; f <= 3; f++) push_frame(1'b1, 16'h0, 1'b1);
    push_frame(1'b0, 16'h8000, 1'b0);
    wait_cyc(5200);
    m_ready = 1'b0;
    push_frame(1'b0, 16'h8000, 1'b0);
    wait_cyc(6410);
    chk("stall_valid_a", m_valid, 1);
    chk("stall_sample_a", {m_chan, m_data}, {2'd0, 16'h8000});
    wait_cyc(7690);
    chk("stall_valid_b", m_valid, 1);
    chk("stall_sample_b", {m_chan, m_unsettled, m_data}, {2'd0, 1'b0, 16'h8000});
    chk("ovr_flag", overrun, 1);
    chk("ovr_cnt", overrun_cnt, 1);
    chk("ovr_frame_cnt", frame_cnt, 5);
    m_ready = 1'b1;
    wait_cyc(7700);
    chk("ovr_drained_idle", m_valid, 0);
    clr_overrun = 1'b1;
    wait_cyc(7701);
    clr_overrun = 1'b0;
    chk("clr_overrun", {overrun, overrun_cnt}, 0);
    push_frame(1'b0, 16'h8000, 1'b0);
    wait_cyc(8970);
    chk("ovr_frame_cnt_after", frame_cnt, 6);
    chk("ovr_queue_empty", q.size(), 0);
    do_reset(4'hF, 1'b0);
    wait_cyc(1290);
    chk("pre_rst_valid", m_valid, 1);
    chk("pre_rst_dac", dac_out, 4'hF);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    chk("mid_rst_dac", dac_out, 0);
    rst = 1'b0;
    m_ready = 1'b1;
    push_frame(1'b1, 16'h0, 1'b1);
    wait_cyc(1283);
    chk("rerun_no_frame_yet", {m_valid, frame_cnt}, 0);
    wait_cyc(1284);
    chk("rerun_first_frame", {m_valid, frame_cnt}, {1'b1, 16'd1});
    wait_cyc(1290);
    chk("rerun_queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
